// File: rtl/vga_scan_driver_if.sv
// Bundle between the VGA scan driver and its pixel core / DAC pins.
// Names follow the driver's view: o_* are driven by the driver, i_* by the core.
//   o_pixel_row/o_pixel_col : coordinate issued to the pixel core (0 when blanked)
//   i_pixel_in              : colour returned by the core, CORE_LAT ticks later
//   o_rgb/o_hsync/o_vsync/o_de : registered pin outputs (syncs active-low)
//   o_vblank_start          : one-clock pulse at the start of vertical blank
interface vga_scan_driver_if #(
    parameter int WCOLOR = 6
);
    logic [8:0]        o_pixel_row;
    logic [9:0]        o_pixel_col;
    logic [WCOLOR-1:0] i_pixel_in;
    logic [WCOLOR-1:0] o_rgb;
    logic              o_hsync;
    logic              o_vsync;
    logic              o_de;
    logic              o_vblank_start;

    modport master (
        output o_pixel_row,
        output o_pixel_col,
        input  i_pixel_in,
        output o_rgb,
        output o_hsync,
        output o_vsync,
        output o_de,
        output o_vblank_start
    );

    modport slave (
        input  o_pixel_row,
        input  o_pixel_col,
        output i_pixel_in,
        input  o_rgb,
        input  o_hsync,
        input  o_vsync,
        input  o_de,
        input  o_vblank_start
    );
endinterface

// File: rtl/vga_scan_driver.sv
// 640x480@60 raster timing generator; feeds row/col to the pixel core and
// realigns sync/blank with the core's latency before registering the pins.
// Ports:
//   i_clk   : pixel clock
//   i_rst   : synchronous reset, active-high (wins over i_en)
//   i_en    : pixel tick; all scan state advances only when high
//   bus     : vga_scan_driver_if.master (core coordinate/colour + pin outputs)
module vga_scan_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CORE_LAT = 1,
    parameter int WCOLOR   = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    vga_scan_driver_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] V_ALAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]          r_h_cnt;
    logic [9:0]          r_v_cnt;
    logic [CORE_LAT-1:0] r_de_pipe;
    logic [CORE_LAT-1:0] r_hs_pipe;
    logic [CORE_LAT-1:0] r_vs_pipe;
    logic [WCOLOR-1:0]   r_rgb;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_de;
    logic                r_vblank;

    logic            w_h_last;
    logic            w_v_last;
    logic            w_de_raw;
    logic            w_hs_raw;
    logic            w_vs_raw;
    logic [CORE_LAT:0] w_de_shift;
    logic [CORE_LAT:0] w_hs_shift;
    logic [CORE_LAT:0] w_vs_shift;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);
    assign w_de_raw = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_raw = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    assign w_vs_raw = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

    // Raw value enters at bit 0; the oldest stage is the MSB of the pipe.
    // Building the shifted word this way also covers CORE_LAT == 1.
    assign w_de_shift = {r_de_pipe, w_de_raw};
    assign w_hs_shift = {r_hs_pipe, w_hs_raw};
    assign w_vs_shift = {r_vs_pipe, w_vs_raw};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_de_pipe <= '0;
            r_hs_pipe <= '1;
            r_vs_pipe <= '1;
            r_rgb     <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_de      <= 1'b0;
            r_vblank  <= 1'b0;
        end else begin
            // Not en-gated: the pulse must drop after one clock even if en stalls.
            r_vblank <= i_en && w_h_last && (r_v_cnt == V_ALAST);
            if (i_en) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
                r_de_pipe <= w_de_shift[CORE_LAT-1:0];
                r_hs_pipe <= w_hs_shift[CORE_LAT-1:0];
                r_vs_pipe <= w_vs_shift[CORE_LAT-1:0];
                r_rgb     <= r_de_pipe[CORE_LAT-1] ? bus.i_pixel_in : '0;
                r_hsync   <= r_hs_pipe[CORE_LAT-1];
                r_vsync   <= r_vs_pipe[CORE_LAT-1];
                r_de      <= r_de_pipe[CORE_LAT-1];
            end
        end
    end

    assign bus.o_pixel_row    = w_de_raw ? r_v_cnt[8:0] : 9'd0;
    assign bus.o_pixel_col    = w_de_raw ? r_h_cnt : 10'd0;
    assign bus.o_rgb          = r_rgb;
    assign bus.o_hsync        = r_hsync;
    assign bus.o_vsync        = r_vsync;
    assign bus.o_de           = r_de;
    assign bus.o_vblank_start = r_vblank;
endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench for vga_scan_driver: one full-size instance for line timing,
// one with a shortened vertical frame so whole-frame behaviour stays short.
module tb_vga_scan_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic en_a;
    logic rst_b;
    logic en_b;
    int   checks = 0;
    int   errors = 0;

    vga_scan_driver_if ia ();
    vga_scan_driver_if ib ();

    vga_scan_driver ua (
        .i_clk (clk),
        .i_rst (rst_a),
        .i_en  (en_a),
        .bus   (ia.master)
    );

    // Vertical frame: 4 active, 2 fp, 2 sync, 1 bp = 9 lines
    vga_scan_driver #(
        .V_ACTIVE (4),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (1)
    ) ub (
        .i_clk (clk),
        .i_rst (rst_b),
        .i_en  (en_b),
        .bus   (ib.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int e;
    int lows;
    int pulses;
    int pedge;
    int nen;
    int h;
    int v;

    initial begin
        rst_a = 1'b1;
        en_a  = 1'b1;
        rst_b = 1'b1;
        en_b  = 1'b1;
        ia.i_pixel_in = 6'h2A;
        ib.i_pixel_in = 6'h2A;
        repeat (3) tick();

        // Reset state
        chk("rst_hsync", ia.o_hsync, 1);
        chk("rst_vsync", ia.o_vsync, 1);
        chk("rst_rgb", ia.o_rgb, 0);
        chk("rst_de", ia.o_de, 0);
        chk("rst_row", ia.o_pixel_row, 0);
        chk("rst_col", ia.o_pixel_col, 0);
        chk("rst_vbl", ia.o_vblank_start, 0);

        // First columns after release
        rst_a = 1'b0;
        e = 0;
        tick(); e++;
        chk("col1", ia.o_pixel_col, 1);
        tick(); e++;
        chk("col2", ia.o_pixel_col, 2);
        chk("de_e2", ia.o_de, 1);
        tick(); e++;
        chk("col3", ia.o_pixel_col, 3);
        chk("de_e3", ia.o_de, 1);
        chk("rgb_act", ia.o_rgb, 6'h2A);

        // Hsync: first low after edge 658, 96 clocks wide
        while (ia.o_hsync !== 1'b0 && e < 2000) begin
            tick(); e++;
        end
        chk("hs_first", e, 658);
        lows = 0;
        while (ia.o_hsync === 1'b0 && lows < 1000) begin
            lows++;
            tick(); e++;
        end
        chk("hs_width", lows, 96);

        // Blanking forces rgb to 0
        ia.i_pixel_in = 6'h3F;
        tick(); e++;
        chk("blank_rgb", ia.o_rgb, 0);
        chk("blank_de", ia.o_de, 0);
        chk("blank_col", ia.o_pixel_col, 0);
        while (e < 800) begin
            tick(); e++;
        end
        chk("row1_row", ia.o_pixel_row, 1);
        chk("row1_col", ia.o_pixel_col, 0);
        ia.i_pixel_in = 6'h2A;
        tick(); e++;
        chk("row1_col1", ia.o_pixel_col, 1);
        tick(); e++;
        chk("row1_de", ia.o_de, 1);
        chk("row1_rgb", ia.o_rgb, 6'h2A);
        while (ia.o_hsync !== 1'b0 && e < 3000) begin
            tick(); e++;
        end
        chk("hs_period", e, 1458);

        // en alternating: counters advance on odd clocks only
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        lows = 0;
        for (int k = 1; k <= 1800; k++) begin
            en_a = (k % 2) == 1;
            tick();
            nen = (k + 1) / 2;
            h = nen % 800;
            v = nen / 800;
            chk("alt_col", ia.o_pixel_col, (h < 640) ? h : 0);
            chk("alt_row", ia.o_pixel_row, (h < 640) ? v : 0);
            if (ia.o_hsync === 1'b0) lows++;
        end
        chk("alt_hs_width", lows, 192);
        en_a = 1'b1;

        // Shortened frame on instance B
        rst_b = 1'b0;
        pulses = 0;
        pedge = 0;
        lows = 0;
        for (int k = 1; k <= 9100; k++) begin
            tick();
            if (ib.o_vblank_start === 1'b1) begin
                pulses++;
                pedge = k;
            end
            if (ib.o_vsync === 1'b0) lows++;
            if (k == 7200) begin
                chk("wrap_row", ib.o_pixel_row, 0);
                chk("wrap_col", ib.o_pixel_col, 0);
            end
            if (k == 7205) chk("wrap_col5", ib.o_pixel_col, 5);
        end
        chk("vbl_count", pulses, 1);
        chk("vbl_edge", pedge, 3200);
        chk("vs_width", lows, 1600);
        chk("mid_row", ib.o_pixel_row, 2);
        chk("mid_col", ib.o_pixel_col, 300);

        // Reset mid-frame
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("mrst_row", ib.o_pixel_row, 0);
        chk("mrst_col", ib.o_pixel_col, 0);
        chk("mrst_hsync", ib.o_hsync, 1);
        chk("mrst_vsync", ib.o_vsync, 1);
        chk("mrst_de", ib.o_de, 0);
        chk("mrst_rgb", ib.o_rgb, 0);
        chk("mrst_vbl", ib.o_vblank_start, 0);
        pulses = 0;
        pedge = 0;
        for (int k = 1; k <= 3300; k++) begin
            tick();
            if (ib.o_vblank_start === 1'b1) begin
                pulses++;
                pedge = k;
            end
            if (k == 1) chk("mrst_col1", ib.o_pixel_col, 1);
        end
        chk("mrst_vbl_count", pulses, 1);
        chk("mrst_vbl_edge", pedge, 3200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
